// File: rtl/pf_tile_fetch.sv
// Playfield tile fetch sequencer. Each line it reads one map row from VRAM and hands
// the decoded tile entries to the pixel pipeline.

// Tile entry FIFO with a synchronous flush. A pop is ignored while the FIFO is empty.
// Latency: a pushed entry reaches the head one cycle after the push.
// Backpressure: the FIFO does not guard against overflow; the producer must respect o_full.
module pf_tile_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_pop;

    assign o_vld  = (r_count != '0);
    assign o_full = (r_count == DEPTH_C);
    assign o_dat  = r_mem[r_rptr];
    assign w_pop  = i_pop && o_vld;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule

// Walks one map row per line. It issues one VRAM read per tile column and decodes each word into the FIFO.
// Latency: vram_req follows line_start by one cycle; returned data reaches tile_valid one cycle after rvalid.
// Backpressure: a request is raised only when the buffered entries plus the outstanding read leave room in the FIFO.
module pf_tile_fetch #(
    parameter int TILES_PER_LINE = 42,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic [8:0]  pfv,
    input  logic [8:0]  pfh,
    output logic        vram_req,
    output logic [11:0] vram_addr,
    input  logic        vram_gnt,
    input  logic        vram_rvalid,
    input  logic [15:0] vram_rdata,
    output logic        tile_valid,
    output logic [11:0] tile_code,
    output logic [2:0]  tile_color,
    output logic        tile_hflip,
    output logic        tile_last,
    input  logic        tile_pop,
    output logic [2:0]  fine_v,
    output logic [2:0]  fine_h,
    output logic        line_done
);
    localparam int            CW    = $clog2(TILES_PER_LINE + 1);
    localparam logic [CW-1:0] TPL_C = CW'(TILES_PER_LINE);

    typedef enum logic [1:0] { IDLE, REQ, WAIT } state_t;

    typedef struct packed {
        logic        last;
        logic        hflip;
        logic [2:0]  color;
        logic [11:0] code;
    } tile_t;

    state_t        r_state;
    logic [5:0]    r_row;
    logic [5:0]    r_col;
    logic [2:0]    r_fine_v;
    logic [2:0]    r_fine_h;
    logic [CW-1:0] r_issued;
    logic          r_discard;
    logic          r_line_done;

    logic  w_fifo_vld;
    logic  w_fifo_full;
    logic  w_outstanding;
    logic  w_gnt;
    logic  w_push;
    logic  w_pop;
    tile_t w_push_dat;
    tile_t w_head;

    // A read abandoned by a restart stays in flight until its rvalid. The discard flag
    // blocks new requests until then, so at most one read is outstanding.
    assign w_outstanding = (r_state == WAIT) || r_discard;
    assign vram_req      = (r_state == REQ) && !r_discard && !w_fifo_full;
    assign w_gnt         = vram_req && vram_gnt;
    assign w_push        = vram_rvalid && (r_state == WAIT) && !r_discard && !line_start && !rst;
    assign w_pop         = tile_pop && w_fifo_vld;

    assign w_push_dat.last  = (r_issued == TPL_C);
    assign w_push_dat.hflip = vram_rdata[15];
    assign w_push_dat.color = vram_rdata[14:12];
    assign w_push_dat.code  = vram_rdata[11:0];

    pf_tile_fifo #(
        .WIDTH ($bits(tile_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (line_start),
        .i_push  (w_push),
        .i_dat   (w_push_dat),
        .i_pop   (tile_pop),
        .o_vld   (w_fifo_vld),
        .o_dat   (w_head),
        .o_full  (w_fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_fine_v    <= '0;
            r_fine_h    <= '0;
            r_issued    <= '0;
            r_discard   <= 1'b0;
            r_line_done <= 1'b0;
        end else begin
            r_line_done <= w_pop && w_head.last;
            if (line_start) begin
                r_row     <= pfv[8:3];
                r_fine_v  <= pfv[2:0];
                r_col     <= pfh[8:3];
                r_fine_h  <= pfh[2:0];
                r_issued  <= '0;
                r_state   <= REQ;
                r_discard <= (w_outstanding && !vram_rvalid) || w_gnt;
            end else begin
                if (r_discard && vram_rvalid) begin
                    r_discard <= 1'b0;
                end
                case (r_state)
                    REQ: begin
                        if (w_gnt) begin
                            r_state  <= WAIT;
                            r_col    <= r_col + 6'd1;
                            r_issued <= r_issued + 1'b1;
                        end
                    end
                    WAIT: begin
                        if (vram_rvalid) begin
                            r_state <= (r_issued < TPL_C) ? REQ : IDLE;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign vram_addr  = {r_row, r_col};
    assign fine_v     = r_fine_v;
    assign fine_h     = r_fine_h;
    assign line_done  = r_line_done;

    // Head fields read as zero while the FIFO is empty.
    assign tile_valid = w_fifo_vld;
    assign tile_code  = w_fifo_vld ? w_head.code  : 12'd0;
    assign tile_color = w_fifo_vld ? w_head.color : 3'd0;
    assign tile_hflip = w_fifo_vld && w_head.hflip;
    assign tile_last  = w_fifo_vld && w_head.last;
endmodule

// File: tb/tb_pf_tile_fetch.sv
// Bench for pf_tile_fetch: a VRAM responder feeds a scoreboard, and a consumer drains it and checks each entry.
`timescale 1ns/1ps
module tb_pf_tile_fetch;
    localparam int TPL   = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [8:0]  pfv;
    logic [8:0]  pfh;
    logic        vram_req;
    logic [11:0] vram_addr;
    logic        vram_gnt;
    logic        vram_rvalid;
    logic [15:0] vram_rdata;
    logic        tile_valid;
    logic [11:0] tile_code;
    logic [2:0]  tile_color;
    logic        tile_hflip;
    logic        tile_last;
    logic        tile_pop;
    logic [2:0]  fine_v;
    logic [2:0]  fine_h;
    logic        line_done;

    typedef struct packed {
        logic        last;
        logic        hflip;
        logic [2:0]  color;
        logic [11:0] code;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [5:0]  exp_row  = '0;
    logic [5:0]  exp_col  = '0;
    int          exp_n    = 0;
    int          rv_delay = 2;
    int          rv_cnt   = 0;
    int          stall_cnt = 0;
    logic        stall_on = 1'b0;
    logic        force_en = 1'b0;
    logic [15:0] force_dat = '0;
    logic [15:0] rv_dat   = '0;
    int          n_gnt    = 0;
    logic        pop_en   = 1'b1;
    int          pop_req  = 0;
    int          pop_done = 0;
    int          done_cnt = 0;
    logic        done_due = 1'b0;

    always #5 clk = ~clk;

    pf_tile_fetch #(
        .TILES_PER_LINE (TPL),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .line_start  (line_start),
        .pfv         (pfv),
        .pfh         (pfh),
        .vram_req    (vram_req),
        .vram_addr   (vram_addr),
        .vram_gnt    (vram_gnt),
        .vram_rvalid (vram_rvalid),
        .vram_rdata  (vram_rdata),
        .tile_valid  (tile_valid),
        .tile_code   (tile_code),
        .tile_color  (tile_color),
        .tile_hflip  (tile_hflip),
        .tile_last   (tile_last),
        .tile_pop    (tile_pop),
        .fine_v      (fine_v),
        .fine_h      (fine_h),
        .line_done   (line_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // VRAM arbiter model: optional grant stall, then a grant, then rvalid rv_delay cycles later.
    initial begin
        logic [15:0] w;
        exp_t        e;
        vram_gnt    = 1'b0;
        vram_rvalid = 1'b0;
        vram_rdata  = '0;
        forever begin
            @(negedge clk);
            vram_gnt    = 1'b0;
            vram_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                if (rv_cnt == rv_delay) chk("req_low_after_gnt", vram_req, 1'b0);
                rv_cnt--;
                if (rv_cnt == 0) begin
                    vram_rvalid = 1'b1;
                    vram_rdata  = rv_dat;
                end
            end else if (vram_req || stall_on) begin
                if (stall_cnt > 0) begin
                    stall_on = 1'b1;
                    chk("stall_req", vram_req, 1'b1);
                    chk("stall_addr", vram_addr, {exp_row, exp_col});
                    stall_cnt--;
                end else begin
                    stall_on = 1'b0;
                    chk("gnt_req", vram_req, 1'b1);
                    chk("gnt_addr", vram_addr, {exp_row, exp_col});
                    exp_n++;
                    w = force_en ? force_dat : 16'($urandom);
                    e.last  = (exp_n == TPL);
                    e.hflip = w[15];
                    e.color = w[14:12];
                    e.code  = w[11:0];
                    sb.push_back(e);
                    exp_col  = exp_col + 6'd1;
                    rv_dat   = w;
                    rv_cnt   = rv_delay;
                    vram_gnt = 1'b1;
                    n_gnt++;
                end
            end
        end
    end

    // Consumer: pops when enabled and checks each head against the scoreboard.
    initial begin
        exp_t e;
        tile_pop = 1'b0;
        forever begin
            @(negedge clk);
            tile_pop = 1'b0;
            if (done_due) begin
                chk("line_done_pulse", line_done, 1'b1);
                done_due = 1'b0;
            end
            if (tile_valid && (pop_en || pop_done < pop_req)) begin
                if (!pop_en) pop_done++;
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("tile_code", tile_code, e.code);
                    chk("tile_color", tile_color, e.color);
                    chk("tile_hflip", tile_hflip, e.hflip);
                    chk("tile_last", tile_last, e.last);
                    if (e.last) done_due = 1'b1;
                end
                tile_pop = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (line_done) done_cnt++;
        end
    end

    initial begin
        #200000;
        chk("watchdog", 1'b0, 1'b1);
        $fatal(1, "watchdog expired");
    end

    // Call right after a negedge; returns one negedge later with line_start low again.
    task automatic start_line(input logic [8:0] v, input logic [8:0] h, input logic chk_req);
        pfv        = v;
        pfh        = h;
        line_start = 1'b1;
        sb.delete();
        exp_row = v[8:3];
        exp_col = h[8:3];
        exp_n   = 0;
        @(negedge clk);
        line_start = 1'b0;
        chk("fine_v", fine_v, v[2:0]);
        chk("fine_h", fine_h, h[2:0]);
        if (chk_req) chk("req_after_start", vram_req, 1'b1);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 800) begin
            @(negedge clk);
            n++;
        end
        chk("line_done_count", done_cnt, target);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("idle_valid", tile_valid, 1'b0);
        chk("idle_req", vram_req, 1'b0);
    endtask

    task automatic wait_gnts(input int target);
        int cyc = 0;
        while (n_gnt < target && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("gnt_wait", n_gnt, target);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", vram_req, 1'b0);
        chk("rst_addr", vram_addr, 12'd0);
        chk("rst_valid", tile_valid, 1'b0);
        chk("rst_code", tile_code, 12'd0);
        chk("rst_color", tile_color, 3'd0);
        chk("rst_hflip", tile_hflip, 1'b0);
        chk("rst_last", tile_last, 1'b0);
        chk("rst_fine_v", fine_v, 3'd0);
        chk("rst_fine_h", fine_h, 3'd0);
        chk("rst_line_done", line_done, 1'b0);
    endtask

    initial begin
        int cyc;
        rst        = 1'b1;
        line_start = 1'b0;
        pfv        = '0;
        pfh        = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // basic line, row 3, fine_v 3
        rv_delay = 2;
        start_line(9'h01B, 9'h000, 1'b1);
        wait_done(1);

        // column wrap from 62
        rv_delay = 1;
        start_line(9'h0A5, 9'h1F0, 1'b1);
        wait_done(2);

        // field decode plus a 10-cycle grant stall
        pop_en    = 1'b0;
        force_en  = 1'b1;
        force_dat = 16'hD5A3;
        stall_cnt = 10;
        rv_delay  = 2;
        start_line(9'h1FF, 9'h03F, 1'b1);
        cyc = 0;
        while (!tile_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("dec_valid", tile_valid, 1'b1);
        chk("dec_hflip", tile_hflip, 1'b1);
        chk("dec_color", tile_color, 3'd5);
        chk("dec_code", tile_code, 12'h5A3);
        pop_en = 1'b1;
        wait_done(3);
        force_en = 1'b0;

        // backpressure: FIFO fills and requests stop until a pop
        pop_en   = 1'b0;
        rv_delay = 3;
        n_gnt    = 0;
        start_line(9'h040, 9'h018, 1'b1);
        repeat (60) @(negedge clk);
        chk("bp_grants", n_gnt, DEPTH);
        chk("bp_req_low", vram_req, 1'b0);
        chk("bp_valid", tile_valid, 1'b1);
        pop_req++;
        repeat (30) @(negedge clk);
        chk("bp_grants_after_pop", n_gnt, DEPTH + 1);
        chk("bp_req_low2", vram_req, 1'b0);
        pop_en = 1'b1;
        wait_done(4);

        // restart during WAIT: old entries flushed, in-flight word discarded
        pop_en    = 1'b0;
        rv_delay  = 2;
        force_en  = 1'b1;
        force_dat = 16'hFFFF;
        n_gnt     = 0;
        start_line(9'h088, 9'h008, 1'b1);
        wait_gnts(3);
        @(negedge clk);
        force_en = 1'b0;
        start_line(9'h111, 9'h1F8, 1'b0);
        chk("restart_flushed", tile_valid, 1'b0);
        pop_en = 1'b1;
        wait_done(5);

        // reset mid-line with two entries buffered and one read in flight
        pop_en   = 1'b0;
        rv_delay = 2;
        n_gnt    = 0;
        start_line(9'h0F0, 9'h020, 1'b1);
        wait_gnts(3);
        @(negedge clk);
        chk("pre_rst_valid", tile_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        sb.delete();
        repeat (10) @(negedge clk);
        chk("late_rvalid_valid", tile_valid, 1'b0);
        chk("late_rvalid_req", vram_req, 1'b0);
        chk("done_total", done_cnt, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
